// File: rtl/cpu_pkg_s.sv
// ============================================================================
// cpu_pkg_s : shared CPU types and constants (fetch FSM states, opcodes, NOP)
// Revision  : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg_s;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  // RV32I major opcodes used by the decoder
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

`default_nettype wire

// File: rtl/fetch_s.sv
// ============================================================================
// fetch_s : instruction fetch stage, one outstanding imem request, IF/ID reg
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_s
  import cpu_pkg_s::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);

  fetch_state_t    state_q;
  fetch_state_t    state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_pc_q;
  logic            slot_free;
  logic            req_fire;
  logic            capture;

  assign imem_req_addr = pc_q;

  // Requests only go out when the output slot will be free, so a capture
  // can never overwrite an unconsumed instruction.
  always_comb begin
    slot_free      = !id_valid || id_ready;
    imem_req_valid = !rst && (state_q == S_REQ) && slot_free && !redirect_valid;
    req_fire       = imem_req_valid && imem_req_ready;
    capture        = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (req_fire) state_d = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_d = S_REQ;
               else if (redirect_valid) state_d = S_DRAIN;
      S_DRAIN: if (imem_rsp_valid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (req_fire) begin
      pend_pc_q <= pc_q;
      pc_q      <= pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
    end else if (redirect_valid) begin
      id_valid <= 1'b0;
    end else if (capture) begin
      id_valid <= 1'b1;
      id_instr <= imem_rsp_data;
      id_pc    <= pend_pc_q;
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_s.sv
// ============================================================================
// tb_fetch_s : randomized + directed bench for fetch_s against a queue model
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_s;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr, id_pc;

  // second instance to observe the PC wrap from the top of the address space
  logic        req2_valid, rsp2_valid, id2_valid;
  logic [31:0] req2_addr, id2_instr, id2_pc;
  logic [31:0] addr2_log [$];

  always #5 clk = ~clk;

  fetch_s dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc)
  );

  fetch_s #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req_valid(req2_valid), .imem_req_ready(1'b1),
    .imem_req_addr(req2_addr),
    .imem_rsp_valid(rsp2_valid), .imem_rsp_data(32'h0000_0013),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_ready(1'b1), .id_valid(id2_valid), .id_instr(id2_instr), .id_pc(id2_pc)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) rsp2_valid <= 1'b0;
    else     rsp2_valid <= req2_valid;
  end

  always @(posedge clk) begin
    if (!rst && req2_valid) addr2_log.push_back(req2_addr);
  end

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } req_t;

  req_t        q [$];
  logic [31:0] mpc;
  bit          exp_valid;
  logic [31:0] exp_instr, exp_pc;

  // memory responder
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat = 1;

  // last-cycle observations
  bit          obs_req, obs_idv;
  logic [31:0] obs_addr, obs_pc;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mpc       = 32'h0;
    exp_valid = 1'b0;
    mem_busy  = 1'b0;
    mem_cnt   = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0000_0013);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance it.
  task automatic step(input bit ir, input bit rr, input bit rd, input logic [31:0] rpc);
    bit exp_req, cap, rsp;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_of(mem_addr);
      end else begin
        mem_cnt--;
      end
    end
    id_ready       = ir;
    imem_req_ready = rr;
    redirect_valid = rd;
    redirect_pc    = rpc;
    #1;
    exp_req = (q.size() == 0) && (!exp_valid || ir) && !rd;
    chk("id_valid", {31'b0, id_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk("id_instr", id_instr, exp_instr);
      chk("id_pc", id_pc, exp_pc);
    end
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    if (exp_req) chk("req_addr", imem_req_addr, mpc);
    obs_req  = imem_req_valid;
    obs_addr = imem_req_addr;
    obs_idv  = id_valid;
    obs_pc   = id_pc;
    rsp      = imem_rsp_valid;

    @(posedge clk);
    cap = rsp && (q.size() > 0) && !q[0].stale && !rd;
    if (rd)                       exp_valid = 1'b0;
    else if (cap) begin
      exp_valid = 1'b1;
      exp_instr = word_of(q[0].addr);
      exp_pc    = q[0].addr;
    end else if (exp_valid && ir) exp_valid = 1'b0;
    if (rsp && q.size() > 0) void'(q.pop_front());
    if (rd) begin
      foreach (q[i]) q[i].stale = 1'b1;
      mpc = {rpc[31:2], 2'b00};
    end else if (exp_req && rr) begin
      q.push_back('{addr: mpc, stale: 1'b0});
      mpc = mpc + 32'd4;
    end
    if (rsp) mem_busy = 1'b0;
    if (obs_req && rr) begin
      mem_busy = 1'b1;
      mem_cnt  = lat - 1;
      mem_addr = obs_addr;
    end
  endtask

  initial begin
    int          vidx [$];
    logic [31:0] vpc  [$];
    logic [31:0] held;
    bit          found, saw_v;

    #1 rst = 1'b1;
    do_reset();

    // back-to-back fetch with 1-cycle memory
    lat = 1;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 0);
      if (obs_idv) begin
        vidx.push_back(i);
        vpc.push_back(obs_pc);
      end
    end
    chk("seq_count", vidx.size(), 3);
    if (vidx.size() == 3) begin
      chk("seq_pc0", vpc[0], 32'h0);
      chk("seq_pc1", vpc[1], 32'h4);
      chk("seq_pc2", vpc[2], 32'h8);
      chk("seq_gap0", vidx[1] - vidx[0], 2);
      chk("seq_gap1", vidx[2] - vidx[1], 2);
    end

    // downstream stall: output held, no request
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0);
      chk("stall_idv", {31'b0, obs_idv}, 32'h1);
      chk("stall_pc", obs_pc, 32'hC);
      chk("stall_req", {31'b0, obs_req}, 32'h0);
    end

    // memory backpressure: request and address held
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      chk("bp_req", {31'b0, obs_req}, 32'h1);
      chk("bp_addr", obs_addr, 32'h10);
    end
    lat = 3;
    step(1, 1, 0, 0);

    // redirect while waiting on a slow response
    step(1, 1, 1, 32'h0000_0102);
    found = 0; saw_v = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 1, 0, 0);
      if (obs_idv) saw_v = 1;
      if (obs_req) found = 1;
    end
    chk("redir_found", {31'b0, found}, 32'h1);
    chk("redir_addr", obs_addr, 32'h100);
    chk("redir_no_stale", {31'b0, saw_v}, 32'h0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 1, 0, 0);
      if (obs_idv) found = 1;
    end
    chk("redir_cap_found", {31'b0, found}, 32'h1);
    chk("redir_cap_pc", obs_pc, 32'h100);

    // redirect coinciding with a response
    lat   = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_busy && mem_cnt == 0) found = 1;
      else step(1, 1, 0, 0);
    end
    chk("coinc_found", {31'b0, found}, 32'h1);
    step(1, 1, 1, 32'h0000_0200);
    chk("coinc_rsp", {31'b0, imem_rsp_valid}, 32'h1);
    step(0, 1, 0, 0);
    chk("coinc_flushed", {31'b0, obs_idv}, 32'h0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 1, 0, 0);
      if (obs_idv) found = 1;
    end
    chk("coinc_cap_pc", obs_pc, 32'h200);

    // redirect while an instruction is held
    step(0, 1, 1, 32'h0000_0300);
    chk("held_idv", {31'b0, obs_idv}, 32'h1);
    step(0, 1, 0, 0);
    chk("held_flushed", {31'b0, obs_idv}, 32'h0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 1, 0, 0);
      if (obs_idv) found = 1;
    end
    chk("held_cap_pc", obs_pc, 32'h300);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!mem_busy) lat = $urandom_range(1, 3);
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 19) == 0), $urandom);
    end

    // reset in the middle of a wait
    lat   = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 1, 0, 0);
      if (mem_busy) found = 1;
    end
    chk("midrst_wait", {31'b0, found}, 32'h1);
    do_reset();
    held = 32'h0;
    for (int i = 0; i < 200; i++) begin
      if (!mem_busy) lat = $urandom_range(1, 3);
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 29) == 0), $urandom);
    end

    // wrap of the sequential PC
    chk("wrap_log", {31'b0, addr2_log.size() >= 2}, 32'h1);
    if (addr2_log.size() >= 2) begin
      chk("wrap_addr0", addr2_log[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", addr2_log[1], 32'h0000_0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
